// File: rtl/timer_arbiter.sv
// Round-robin scheduler sharing one BW-bit interval counter between NREQ requesters.
// Grants one requester at a time, counts its interval, pulses its done line, re-arbitrates.
module timer_arbiter #(
  parameter int NREQ = 4,
  parameter int BW   = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ*BW-1:0] dur_i,
  output logic [NREQ-1:0]   grant_o,
  output logic [NREQ-1:0]   done_o,
  output logic [BW-1:0]     count_o,
  output logic              busy_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic [IW-1:0] ptr_reg, ptr_next;
  logic [BW-1:0] dur_reg, dur_next;
  logic [BW-1:0] cnt_reg, cnt_next;

  logic [BW-1:0]   dur_arr [NREQ];
  logic [NREQ-1:0] idx_onehot;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   idx_inc;
  logic [IW:0]     cand;
  logic            found;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign dur_arr[gi]    = dur_i[gi*BW +: BW];
      assign idx_onehot[gi] = (idx_reg == IW'(gi));
    end
  endgenerate

  // Priority search starting at ptr, wrapping modulo NREQ (works for non-power-of-two NREQ).
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_reg} + (IW+1)'(i);
      if (cand >= (IW+1)'(NREQ)) begin
        cand = cand - (IW+1)'(NREQ);
      end
      if (!found && req_i[cand[IW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end
    end
  end

  assign idx_inc = (idx_reg == IW'(NREQ-1)) ? '0 : idx_reg + IW'(1);

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    ptr_next   = ptr_reg;
    dur_next   = dur_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (found) begin
          idx_next   = pick;
          dur_next   = dur_arr[pick];
          cnt_next   = '0;
          state_next = (dur_arr[pick] != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        // Abort wins over terminal count: a dropped request never sees a done pulse.
        if (!req_i[idx_reg]) begin
          state_next = IDLE;
          ptr_next   = idx_inc;
          cnt_next   = '0;
        end else if (cnt_reg == dur_reg - BW'(1)) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt_reg + BW'(1);
        end
      end
      DONE: begin
        ptr_next   = idx_inc;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      ptr_reg   <= '0;
      dur_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      ptr_reg   <= ptr_next;
      dur_reg   <= dur_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Outputs decode registered state only, so reset clears them without waiting for a clock.
  assign grant_o = (state_reg == RUN)  ? idx_onehot : '0;
  assign done_o  = (state_reg == DONE) ? idx_onehot : '0;
  assign count_o = (state_reg == RUN)  ? cnt_reg    : '0;
  assign busy_o  = (state_reg != IDLE);

endmodule

// File: doc/timer_arbiter.md
# timer_arbiter

Round-robin scheduler that shares one interval counter between `NREQ` requesters. Each requester asks for a timed interval of `dur` cycles. The block grants the counter to one requester at a time, counts the interval, pulses that requester's done line, then re-arbitrates. It sits between the requesting control logic and the free-running counter datapath, and replaces per-requester counters with one shared `BW`-bit counter.

## Interface

- `NREQ`, 4, number of requesters (≥2)
- `BW`, 8, counter / duration width (≥2)

- `clk_i`  in  1  clock, all state on rising edge
- `rst_n_i`  in  1  reset, asynchronous, active-low
- `req_i`  in  NREQ  per-requester request level; must stay high until done or abort
- `dur_i`  in  NREQ*BW  packed durations; requester k uses `dur_i[k*BW +: BW]`
- `grant_o`  out  NREQ  one-hot; high for the granted requester while in RUN
- `done_o`  out  NREQ  one-cycle pulse on the granted bit when the interval completes
- `count_o`  out  BW  current count in RUN, 0 otherwise
- `busy_o`  out  1  high whenever state ≠ IDLE

## Operation

- **State machine:** IDLE, RUN, DONE. Internal registers: `idx` (granted requester), `dur_q` (latched duration), `cnt`, round-robin pointer `ptr`.
- **IDLE:**
  - If `req_i` ≠ 0, pick the first set bit searching `ptr`, `ptr+1`, … and wrapping mod `NREQ`.
  - Latch `idx` and `dur_q = dur_i[idx]`, and set `cnt = 0`.
  - Next state is RUN if `dur_q` ≠ 0, else DONE.
- **RUN:**
  - `cnt` increments by 1 each cycle.
  - When `cnt == dur_q-1`, the next state is DONE. RUN therefore lasts exactly `dur_q` cycles.
  - **Abort:** if `req_i[idx]` is 0 in any RUN cycle, the next state is IDLE. No done pulse, `ptr = idx+1 mod NREQ`, `cnt` cleared. Abort takes priority over the terminal count.
- **DONE:** one cycle. `done_o[idx]` = 1 and `grant_o` = 0. Set `ptr = idx+1 mod NREQ`, then go to IDLE.
- **Duration latching:** `dur_i` and the other requesters' `req_i` are ignored outside IDLE. Changes to `dur_i` after latching have no effect.
- **Re-request:** a requester still holding `req_i` in IDLE after its done is eligible again. It is served only after the others by round-robin order.
- **Arithmetic:** `cnt` is `BW`-bit unsigned and never wraps, since its maximum is `dur_q-1` ≤ 2^BW−2. Duration range is 0…2^BW−1.
- **Reset:** on `rst_n_i` = 0, immediately and asynchronously:
  - state = IDLE, `ptr` = 0, `idx`/`dur_q`/`cnt` = 0;
  - all outputs = 0, with no done pulse, including when reset hits mid-RUN or in DONE.

## Timing

- Request sampled in IDLE at cycle t gives `grant_o` high from t+1 to t+dur.
- `count_o` = 0, 1, …, dur−1 over those cycles.
- `done_o` pulses at t+dur+1, with `busy_o` high from t+1 to t+dur+1.
- IDLE at t+dur+2; the earliest next grant is at t+dur+3. Throughput is one interval per dur+2 cycles.
- `dur` = 0: DONE at t+1 with `grant_o` never high.
- Abort observed at RUN cycle u: IDLE at u+1, `busy_o` low at u+1.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Test plan

- **Single request:** NREQ=4, BW=8, `req_i`=0001, dur0=3 from IDLE at t -> `grant_o`=0001 at t+1..t+3, `count_o` 0,1,2, `done_o`=0001 at t+4 only, `busy_o` low at t+5.
- **Round-robin fairness:** `req_i`=1111 held, all durations 2, each requester dropping req after its done -> grant order 0,1,2,3, exactly one done per requester. Then re-raise req0 and req1: req0 regains the grant because `ptr` wrapped to 0.
- **Zero duration:** `req_i`=0100, dur2=0 -> `done_o`=0100 at t+1, `grant_o` stays 0000, IDLE at t+2.
- **Abort:** dur0=5, req1 pending; drop req0 when `count_o`=1 -> IDLE next cycle, no `done_o`, then `grant_o`=0010 one cycle later.
- **Async reset mid-RUN:** assert `rst_n_i` low between clock edges while `count_o`=4 -> all outputs 0 immediately. After release with `req_i`=1001 -> grant goes to requester 0 (`ptr`=0).
- **Max duration and latching:** dur3=255, change `dur_i` to 1 after the grant -> `count_o` reaches 254, `done_o`=1000 at t+256, no early completion.
